sys_cmd_master: RTL and testbench
=================================

Name: sys_cmd_master

Overview:
- Host-side command initiator for the UART system register-file/ALU command protocol.
- Turns one parallel command request into the protocol byte sequence on the UART TX parallel interface.
- Collects the response bytes from the UART RX parallel interface and returns one assembled result with a timeout flag.
- Used as the stimulus/host end of the system link (bench top and FPGA loopback harness).

Parameters:
- DATA_WIDTH, 8, width of each UART frame byte and of the operand fields.
- TIMEOUT_CYCLES, 1024, number of idle cycles allowed between response bytes before the command is aborted.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset; asynchronous, active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_type  input  2  0=RF_WR (0xAA), 1=RF_RD (0xBB), 2=ALU_OP (0xCC), 3=ALU_NOP (0xDD).
- cmd_addr  input  DATA_WIDTH  register address (RF_WR, RF_RD).
- cmd_data_a  input  DATA_WIDTH  write data (RF_WR) or operand A (ALU_OP).
- cmd_data_b  input  DATA_WIDTH  operand B (ALU_OP).
- cmd_fun  input  4  ALU function (ALU_OP, ALU_NOP); sent zero-extended to DATA_WIDTH.
- TX_P_Data  output  DATA_WIDTH  byte to the UART transmitter.
- TX_D_VLD  output  1  TX_P_Data is valid.
- tx_busy  input  1  transmitter cannot accept; a byte is accepted in any cycle with TX_D_VLD=1 and tx_busy=0.
- RX_P_Data  input  DATA_WIDTH  byte from the UART receiver.
- RX_D_VLD  input  1  single-cycle strobe marking a valid RX_P_Data.
- rsp_valid  output  1  one-cycle pulse; command complete.
- rsp_data  output  2*DATA_WIDTH  result: {hi,lo} for ALU commands, {0,byte} for RF_RD, 0 for RF_WR.
- rsp_timeout  output  1  qualified by rsp_valid; the response did not complete.

Behaviour:
- Reset values: cmd_ready=1, TX_D_VLD=0, TX_P_Data=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, state IDLE, timeout counter 0. All outputs are registered.
- States: IDLE, SEND, WAIT_LO, WAIT_HI, DONE.
- Byte sequences and expected response byte count:
  - RF_WR: AA, addr, data; 0 response bytes.
  - RF_RD: BB, addr; 1 response byte.
  - ALU_OP: CC, A, B, fun; 2 response bytes.
  - ALU_NOP: DD, fun; 2 response bytes.
- IDLE:
  - cmd_valid&&cmd_ready latches all cmd fields and clears rsp_data.
  - Next cycle: state SEND, TX_D_VLD=1, TX_P_Data=opcode, cmd_ready=0.
- SEND:
  - TX_P_Data is held stable until the byte is accepted.
  - On acceptance the next byte appears the following cycle, so TX_D_VLD stays high back-to-back.
  - After the last byte is accepted: TX_D_VLD=0 next cycle.
  - Next state is DONE for RF_WR, WAIT_LO for all other commands.
- WAIT_LO / WAIT_HI:
  - Each RX_D_VLD captures RX_P_Data into rsp_data[7:0] (first byte) or rsp_data[15:8] (second byte).
  - RF_RD goes to DONE after one byte; ALU commands go to DONE after two.
- Timeout counter:
  - Cleared on entry to WAIT_LO and on every accepted RX byte.
  - Increments each wait cycle without RX_D_VLD.
  - At TIMEOUT_CYCLES-1 with no RX_D_VLD: go to DONE with rsp_timeout=1. rsp_data holds whatever bytes were captured; missing bytes stay 0.
  - If RX_D_VLD arrives in that same cycle, the byte wins and no timeout occurs.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE with cmd_ready=1 the following cycle.
- Latency: RF_RD response byte strobe at cycle n gives rsp_valid at n+1.
- RX_D_VLD in IDLE, SEND or DONE is a stray byte: discarded, with no state change.
- cmd_valid outside IDLE is ignored; the request is not queued.
- tx_busy held high indefinitely: SEND stalls with no timeout. The timeout applies to the response only.
- Async reset mid-command: immediate return to the reset values. A partly sent frame is abandoned; re-synchronising the far end is the bench's job.

Optional Feature:
- Macro SYS_CMD_MASTER_STATS_EN.
- When defined, two outputs are added:
  - stray_cnt (8 bits): saturating count of stray RX bytes.
  - timeout_cnt (8 bits): saturating count of timeouts.
  - Both reset to 0 on RST, saturate at 0xFF and are never cleared otherwise.
- When undefined, neither port nor the counters exist and behaviour is otherwise identical.

Test Plan:
- RF_WR addr=0x05 data=0x3C, tx_busy=0 -> TX bytes AA,05,3C on consecutive cycles; rsp_valid one cycle later with rsp_data=0x0000, rsp_timeout=0.
- RF_RD addr=0x02, RX byte 0x7E returned 20 cycles after the last TX byte -> rsp_data=0x007E, rsp_valid exactly 1 cycle after the RX strobe.
- ALU_OP A=0x10 B=0x20 fun=0x2 with tx_busy toggling 1/0 -> CC,10,20,02 each held until accepted; RX bytes 0x00 then 0x02 -> rsp_data=0x0200.
- ALU_NOP fun=0x8, only one RX byte 0x55, TIMEOUT_CYCLES=16 -> rsp_valid with rsp_timeout=1 and rsp_data=0x0055, exactly 16 wait cycles after the byte.
- RX strobe during SEND plus cmd_valid during WAIT_LO -> both ignored; the response completes normally; stray_cnt=1 when SYS_CMD_MASTER_STATS_EN is defined.
- RST asserted while in SEND on the second byte -> TX_D_VLD=0 and cmd_ready=1 immediately; a new RF_RD after release runs correctly.

Source files
------------

// File: rtl/sys_cmd_master.sv
// Host-side command initiator: serialises one command onto the UART TX byte interface and
// assembles the response bytes from UART RX. Define SYS_CMD_MASTER_STATS_EN for stray/timeout counters.
module sys_cmd_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [DATA_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data_a,
    input  logic [DATA_WIDTH-1:0]   cmd_data_b,
    input  logic [3:0]              cmd_fun,
    output logic [DATA_WIDTH-1:0]   TX_P_Data,
    output logic                    TX_D_VLD,
    input  logic                    tx_busy,
    input  logic [DATA_WIDTH-1:0]   RX_P_Data,
    input  logic                    RX_D_VLD,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_timeout,
`ifdef SYS_CMD_MASTER_STATS_EN
    output logic [7:0]              stray_cnt,
    output logic [7:0]              timeout_cnt,
`endif
    output logic [2:0]              dbg_state
);
    // Handshakes: a command transfers on cmd_valid && cmd_ready; a TX byte transfers on
    // TX_D_VLD && !tx_busy; RX_D_VLD is a one-cycle strobe with no back-pressure.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [DATA_WIDTH-1:0] OP_RF_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RF_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] ZERO_BYTE  = '0;

    typedef enum logic [1:0] {CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP} cmd_t;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_LO, WAIT_HI, DONE} state_t;

    state_t                         state_q, state_d;
    cmd_t                           type_q, type_d;
    logic [3:0][DATA_WIDTH-1:0]     frame_q, frame_d;
    logic [1:0]                     last_q, last_d;
    logic [1:0]                     idx_q, idx_d;
    logic [DATA_WIDTH-1:0]          tx_data_q, tx_data_d;
    logic                           tx_vld_q, tx_vld_d;
    logic                           ready_q, ready_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [2*DATA_WIDTH-1:0]        rsp_data_q, rsp_data_d;
    logic                           rsp_tmo_q, rsp_tmo_d;
    logic [CNT_W-1:0]               tmo_cnt_q, tmo_cnt_d;
    logic [DATA_WIDTH-1:0]          fun_ext;

    assign fun_ext = DATA_WIDTH'(cmd_fun);

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        frame_d     = frame_q;
        last_d      = last_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_vld_d    = tx_vld_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_tmo_d   = rsp_tmo_q;
        tmo_cnt_d   = tmo_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    type_d     = cmd_t'(cmd_type);
                    rsp_data_d = '0;
                    rsp_tmo_d  = 1'b0;
                    idx_d      = 2'd0;
                    unique case (cmd_t'(cmd_type))
                        CMD_RF_WR: begin
                            frame_d = {ZERO_BYTE, cmd_data_a, cmd_addr, OP_RF_WR};
                            last_d  = 2'd2;
                        end
                        CMD_RF_RD: begin
                            frame_d = {ZERO_BYTE, ZERO_BYTE, cmd_addr, OP_RF_RD};
                            last_d  = 2'd1;
                        end
                        CMD_ALU_OP: begin
                            frame_d = {fun_ext, cmd_data_b, cmd_data_a, OP_ALU_OP};
                            last_d  = 2'd3;
                        end
                        default: begin
                            frame_d = {ZERO_BYTE, ZERO_BYTE, fun_ext, OP_ALU_NOP};
                            last_d  = 2'd1;
                        end
                    endcase
                    tx_data_d = frame_d[0];
                    tx_vld_d  = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_vld_q && !tx_busy) begin
                    if (idx_q == last_q) begin
                        tx_vld_d  = 1'b0;
                        tmo_cnt_d = '0;
                        if (type_q == CMD_RF_WR) begin
                            rsp_valid_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            state_d = WAIT_LO;
                        end
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = frame_q[idx_d];
                    end
                end
            end
            WAIT_LO, WAIT_HI: begin
                // A byte arriving on the last allowed cycle still wins over the timeout.
                if (RX_D_VLD) begin
                    tmo_cnt_d = '0;
                    if (state_q == WAIT_LO) begin
                        rsp_data_d[DATA_WIDTH-1:0] = RX_P_Data;
                    end else begin
                        rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = RX_P_Data;
                    end
                    if (state_q == WAIT_HI || type_q == CMD_RF_RD) begin
                        rsp_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = WAIT_HI;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            type_q      <= CMD_RF_WR;
            frame_q     <= '0;
            last_q      <= 2'd0;
            idx_q       <= 2'd0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tmo_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            frame_q     <= frame_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tmo_q   <= rsp_tmo_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign TX_P_Data   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_tmo_q;
    assign dbg_state   = state_q;

`ifdef SYS_CMD_MASTER_STATS_EN
    logic       stray_evt;
    logic       tmo_evt;
    logic [7:0] stray_cnt_q;
    logic [7:0] timeout_cnt_q;

    assign stray_evt = RX_D_VLD && (state_q == IDLE || state_q == SEND || state_q == DONE);
    assign tmo_evt   = !RX_D_VLD && (state_q == WAIT_LO || state_q == WAIT_HI) &&
                       (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stray_cnt_q   <= 8'd0;
            timeout_cnt_q <= 8'd0;
        end else begin
            if (stray_evt && stray_cnt_q != 8'hFF) begin
                stray_cnt_q <= stray_cnt_q + 8'd1;
            end
            if (tmo_evt && timeout_cnt_q != 8'hFF) begin
                timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
        end
    end

    assign stray_cnt   = stray_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_sys_cmd_master.sv
// Randomised scoreboard bench for sys_cmd_master: a command driver plays the far-end UART,
// a negedge monitor checks every TX byte and every response against the queued expectations.
module tb_sys_cmd_master;
  localparam int TMO = 32;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [7:0]  cmd_addr = 8'd0;
  logic [7:0]  cmd_data_a = 8'd0;
  logic [7:0]  cmd_data_b = 8'd0;
  logic [3:0]  cmd_fun = 4'd0;
  logic [7:0]  TX_P_Data;
  logic        TX_D_VLD;
  logic        tx_busy = 1'b0;
  logic [7:0]  RX_P_Data = 8'd0;
  logic        RX_D_VLD = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic [2:0]  dbg_state;
`ifdef SYS_CMD_MASTER_STATS_EN
  logic [7:0]  stray_cnt;
  logic [7:0]  timeout_cnt;
`endif

  sys_cmd_master #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data_a(cmd_data_a), .cmd_data_b(cmd_data_b), .cmd_fun(cmd_fun),
    .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .tx_busy(tx_busy),
    .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
`ifdef SYS_CMD_MASTER_STATS_EN
    .stray_cnt(stray_cnt), .timeout_cnt(timeout_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_tx_q[$];
  logic [48:0] exp_rsp_q[$];  // {cycle[31:0], timeout, data[15:0]}
  int exp_stray = 0;
  int exp_tmo = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic       prev_acc = 1'b0;
  logic       prev_more = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_rsp = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      prev_acc  = 1'b0;
      prev_hold = 1'b0;
      prev_rsp  = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("tx_hold_vld", TX_D_VLD, 1'b1);
        chk("tx_hold_data", TX_P_Data, prev_data);
      end
      if (prev_acc) chk("tx_next_vld", TX_D_VLD, prev_more);
      if (TX_D_VLD && !tx_busy) begin
        if (exp_tx_q.size() == 0) begin
          chk("tx_unexpected", 1'b1, 1'b0);
        end else begin
          chk("tx_byte", TX_P_Data, exp_tx_q.pop_front());
        end
        prev_more = (exp_tx_q.size() != 0);
      end
      prev_acc  = TX_D_VLD && !tx_busy;
      prev_hold = TX_D_VLD && tx_busy;
      prev_data = TX_P_Data;
      if (prev_rsp) chk("rsp_pulse_then_ready", {rsp_valid, cmd_ready}, 2'b01);
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          logic [48:0] e;
          e = exp_rsp_q.pop_front();
          chk("rsp_data", rsp_data, e[15:0]);
          chk("rsp_timeout", rsp_timeout, e[16]);
          chk("rsp_cycle", cyc, e[48:17]);
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  // ---------------- driver / reference model ----------------
  // busy_mode: 0 never busy, 1 toggling starting busy, 2 random ~30% busy.
  // d0/d1: idle wait cycles before each response byte; >= TMO means the byte never comes.
  task automatic do_cmd(input logic [1:0] t, input logic [7:0] addr, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] fun, input int busy_mode,
                        input int d0, input logic [7:0] r0, input int d1, input logic [7:0] r1,
                        input bit stray_send, input bit cmd_in_wait, input bit stray_idle);
    logic [7:0]  frame[$];
    int          n_rsp;
    int          acc;
    int          guard;
    int          ref_c;
    int          rsp_c;
    logic        tmo;
    logic [15:0] data;
    case (t)
      2'd0: begin frame = '{8'hAA, addr, a}; n_rsp = 0; end
      2'd1: begin frame = '{8'hBB, addr}; n_rsp = 1; end
      2'd2: begin frame = '{8'hCC, a, b, {4'h0, fun}}; n_rsp = 2; end
      default: begin frame = '{8'hDD, {4'h0, fun}}; n_rsp = 2; end
    endcase
    guard = 0;
    while (!cmd_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (!cmd_ready) begin
      chk("wait_cmd_ready", 1'b0, 1'b1);
      return;
    end
    if (stray_idle) begin
      RX_D_VLD = 1'b1;
      RX_P_Data = 8'($urandom);
      exp_stray++;
      tick();
      RX_D_VLD = 1'b0;
    end
    foreach (frame[i]) exp_tx_q.push_back(frame[i]);
    cmd_valid = 1'b1;
    cmd_type = t; cmd_addr = addr; cmd_data_a = a; cmd_data_b = b; cmd_fun = fun;
    tick();
    cmd_valid = 1'b0;
    cmd_addr = 8'($urandom); cmd_data_a = 8'($urandom); cmd_data_b = 8'($urandom);
    if (stray_send) begin
      RX_D_VLD = 1'b1;
      RX_P_Data = 8'($urandom);
      exp_stray++;
    end
    acc = 0;
    guard = 0;
    ref_c = cyc;
    tx_busy = (busy_mode == 1);
    while (acc < frame.size() && guard < 500) begin
      if (busy_mode == 2) tx_busy = ($urandom_range(0, 99) < 30);
      if (TX_D_VLD && !tx_busy) begin
        acc++;
        ref_c = cyc;
      end
      tick();
      RX_D_VLD = 1'b0;
      if (busy_mode == 1) tx_busy = ~tx_busy;
      guard++;
    end
    tx_busy = 1'b0;
    if (acc < frame.size()) begin
      chk("send_progress", acc, frame.size());
      return;
    end
    // Expected response from the protocol rules: each byte must arrive within TMO idle cycles.
    tmo = 1'b0;
    data = 16'h0000;
    if (n_rsp == 0) begin
      rsp_c = ref_c + 1;
    end else if (d0 >= TMO) begin
      tmo = 1'b1;
      rsp_c = ref_c + TMO + 1;
    end else begin
      data[7:0] = r0;
      if (n_rsp == 1) begin
        rsp_c = ref_c + d0 + 2;
      end else if (d1 >= TMO) begin
        tmo = 1'b1;
        rsp_c = ref_c + d0 + 1 + TMO + 1;
      end else begin
        data[15:8] = r1;
        rsp_c = ref_c + d0 + 1 + d1 + 2;
      end
    end
    if (tmo) exp_tmo++;
    exp_rsp_q.push_back({rsp_c[31:0], tmo, data});
    if (n_rsp == 0) return;
    if (cmd_in_wait) begin
      cmd_valid = 1'b1;
      cmd_type = 2'($urandom);
      cmd_fun = 4'($urandom);
    end
    if (d0 < TMO) begin
      repeat (d0) begin tick(); cmd_valid = 1'b0; end
      RX_D_VLD = 1'b1; RX_P_Data = r0;
      tick();
      RX_D_VLD = 1'b0; cmd_valid = 1'b0;
      if (n_rsp == 2 && d1 < TMO) begin
        repeat (d1) tick();
        RX_D_VLD = 1'b1; RX_P_Data = r1;
        tick();
        RX_D_VLD = 1'b0;
      end
    end else begin
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_rsp_q.size() != 0 || !cmd_ready) && g < 300) begin
      tick();
      g++;
    end
    chk("rsp_queue_drained", exp_rsp_q.size(), 0);
    chk("tx_queue_drained", exp_tx_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_tx_vld", TX_D_VLD, 1'b0);
    chk("rst_tx_data", TX_P_Data, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_state_idle", dbg_state, 3'd0);
    RST = 1'b1;
    repeat (2) tick();

    do_cmd(2'd0, 8'h05, 8'h3C, 8'h00, 4'h0, 0, 0, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd1, 8'h02, 8'h00, 8'h00, 4'h0, 0, 19, 8'h7E, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd2, 8'h00, 8'h10, 8'h20, 4'h2, 1, 3, 8'h00, 5, 8'h02, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd3, 8'h00, 8'h00, 8'h00, 4'h8, 0, 4, 8'h55, TMO, 8'hEE, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd1, 8'h33, 8'h00, 8'h00, 4'h0, 0, 2, 8'hA5, 0, 8'h00, 1'b1, 1'b1, 1'b0);
    drain();
`ifdef SYS_CMD_MASTER_STATS_EN
    chk("stray_cnt_after_send_stray", stray_cnt, 8'(exp_stray));
`endif
    do_cmd(2'd1, 8'h44, 8'h00, 8'h00, 4'h0, 0, TMO - 1, 8'hC3, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd2, 8'h00, 8'hFF, 8'h01, 4'hF, 2, 0, 8'h12, TMO - 1, 8'h34, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd1, 8'h45, 8'h00, 8'h00, 4'h0, 0, TMO, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b1);
    do_cmd(2'd3, 8'h00, 8'h00, 8'h00, 4'h1, 0, TMO, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();
`ifdef SYS_CMD_MASTER_STATS_EN
    chk("stray_cnt", stray_cnt, 8'(exp_stray));
    chk("timeout_cnt", timeout_cnt, 8'(exp_tmo));
`endif

    // Reset while the second ALU_OP byte is stalled by a busy transmitter.
    begin
      int g;
      g = 0;
      while (!cmd_ready && g < 300) begin tick(); g++; end
      exp_tx_q.push_back(8'hCC);
      exp_tx_q.push_back(8'h6A);
      cmd_valid = 1'b1; cmd_type = 2'd2; cmd_data_a = 8'h6A; cmd_data_b = 8'h01; cmd_fun = 4'h3;
      tick();
      cmd_valid = 1'b0;
      tx_busy = 1'b0;
      tick();
      tx_busy = 1'b1;
      repeat (TMO + 8) tick();
      chk("stall_tx_vld", TX_D_VLD, 1'b1);
      chk("stall_tx_data", TX_P_Data, 8'h6A);
      chk("stall_no_rsp", rsp_valid, 1'b0);
      #2 RST = 1'b0;
      #1;
      chk("async_rst_tx_vld", TX_D_VLD, 1'b0);
      chk("async_rst_cmd_ready", cmd_ready, 1'b1);
      chk("async_rst_tx_data", TX_P_Data, 8'h00);
      exp_tx_q.delete();
      exp_rsp_q.delete();
      exp_stray = 0;
      exp_tmo = 0;
      tx_busy = 1'b0;
      tick();
      tick();
      RST = 1'b1;
      tick();
    end
    do_cmd(2'd1, 8'h09, 8'h00, 8'h00, 4'h0, 0, 6, 8'h9C, 0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int d0;
      int d1;
      d0 = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 8);
      d1 = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 8);
      do_cmd(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
             $urandom_range(0, 2), d0, 8'($urandom), d1, 8'($urandom),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end
    drain();
`ifdef SYS_CMD_MASTER_STATS_EN
    chk("final_stray_cnt", stray_cnt, 8'(exp_stray));
    chk("final_timeout_cnt", timeout_cnt, 8'(exp_tmo));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
